multiword_add_seq: RTL
======================

// Module: multiword_add_seq
// PURPOSE
//  Beat sequencer around the ripple-carry adder datapath. It accepts a multi-word addition as
//  a stream of WIDTH-bit operand beats, least-significant word first. Each beat's carry-out
//  is carried into the next beat's carry-in, so wide sums are built from one WIDTH-bit adder.
//  Each registered sum beat is presented downstream with a valid/ready handshake.
//  Sits between the operand source (upstream) and result consumer; adder is combinational core.
// PARAMETERS
//  WIDTH      8   bits per operand beat / adder width
//  MAX_BEATS  16  max beats per transaction; beat index width = $clog2(MAX_BEATS)
// PORTS
//  clk        in   1          single clock, rising edge
//  reset      in   1          synchronous, active-high
//  in_valid   in   1          operand beat valid
//  in_ready   out  1          beat accepted when in_valid && in_ready
//  in_a       in   WIDTH      operand A word
//  in_b       in   WIDTH      operand B word
//  in_last    in   1          marks most-significant (final) beat
//  out_valid  out  1          sum beat valid
//  out_ready  in   1          sum beat consumed when out_valid && out_ready
//  out_sum    out  WIDTH      sum word for this beat
//  out_idx    out  $clog2(MAX_BEATS)  beat index within transaction (0 = LSW)
//  out_last   out  1          final beat of transaction
//  out_carry  out  1          unsigned carry-out of final beat; 0 on non-last beats
//  out_ovf    out  1          signed overflow of final beat; 0 on non-last beats
//  out_err    out  1          transaction truncated at MAX_BEATS (see below)
// BEHAVIOUR
//  - Reset (sync, high): out_valid=0, out_sum=0, out_idx=0, out_last=0, out_carry=0,
//    out_ovf=0, out_err=0; carry register=0; beat counter=0. Reset mid-transaction abandons it.
//  - in_ready = !out_valid || out_ready (one-entry output register, full throughput, no bubble).
//  - On accept: {c, s} = in_a + in_b + carry_q (WIDTH+1 bits). Register s -> out_sum,
//    cnt -> out_idx, out_valid=1 next cycle. Latency: 1 cycle accept-to-out_valid.
//  - carry_q <= c on non-last beats; carry_q <= 0 after last beat accepted (next txn starts cin=0).
//  - Beat counter increments per accepted beat; clears to 0 after last beat.
//  - Last beat: out_last=1, out_carry=c, out_ovf = (a[MSB]==b[MSB]) && (s[MSB]!=a[MSB]).
//  - Forced last: beat with cnt==MAX_BEATS-1 and in_last=0 is treated as last; out_last=1,
//    out_err=1, carry/counter clear. Next beat starts a fresh transaction.
//  - Backpressure: out_valid && !out_ready -> all out_* held stable, in_ready=0, carry_q held.
//  - Simultaneous out handshake and new accept in same cycle: new beat replaces output, no loss.
//  - out_valid drops only when consumed with no new beat accepted that cycle.
//  - States: implicit 2 (IDLE: cnt==0, carry_q==0; IN_TXN: cnt>0); no extra FSM register.
// STRUCTURE
//  - Shared package add_pkg: WIDTH default, overflow helper function, beat-index width constant.
//  - One sub-module: ripple_adder (WIDTH-bit chain of full_adder cells, cin/cout ports).
//  - This block holds only carry_q, cnt, output register and ready logic.
// TESTING
//  1. Single beat 173+92, in_last=1 -> out_sum=0x09, out_carry=1, out_ovf=0, out_idx=0.
//  2. Two beats 0x12FF+0x0001: {FF,01} then {12,00,last} -> 0x00 (idx0), 0x13 (idx1, carry0).
//  3. Signed overflow 0x7F+0x01 last -> out_sum=0x80, out_carry=0, out_ovf=1.
//  4. Backpressure: out_ready=0 for 3 cycles mid-txn -> in_ready=0, outputs stable, sums correct.
//  5. 16 beats 0xFF+0x01, no in_last -> beat15 out_last=1, out_err=1; next beat's cin=0.
//  6. Reset asserted after beat 0 of 3 -> out_valid=0; fresh beat 0x01+0x01 gives 0x02, idx0.

Source files
------------

// File: rtl/add_pkg.sv
// Shared constants and helpers for the multi-word beat adder.
package add_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_MAX_BEATS = 16;
    localparam int DEF_IDX_W     = $clog2(DEF_MAX_BEATS);

    // Two's-complement overflow: operands agree in sign, and the result disagrees with them.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell used to build the ripple chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/ripple_adder.sv
// WIDTH-bit ripple-carry adder built from a chain of full_adder cells.
module ripple_adder
    import add_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] c;

    assign c[0] = cin;
    assign cout = c[WIDTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (sum[i]),
            .cout (c[i+1])
        );
    end

endmodule

// File: rtl/multiword_add_seq.sv
// Beat sequencer: chains carries across WIDTH-bit operand beats (LSW first) through one
// ripple adder and presents each registered sum beat on a valid/ready output.
module multiword_add_seq
    import add_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MAX_BEATS = DEF_MAX_BEATS
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_a,
    input  logic [WIDTH-1:0]             in_b,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_sum,
    output logic [$clog2(MAX_BEATS)-1:0] out_idx,
    output logic                         out_last,
    output logic                         out_carry,
    output logic                         out_ovf,
    output logic                         out_err
);

    localparam int IDX_W = $clog2(MAX_BEATS);

    logic             carry_q;
    logic [IDX_W-1:0] cnt;

    logic [WIDTH-1:0] s;
    logic             c;
    logic             accept;
    logic             at_limit;
    logic             last_eff;

    ripple_adder #(.WIDTH(WIDTH)) u_adder (
        .a    (in_a),
        .b    (in_b),
        .cin  (carry_q),
        .sum  (s),
        .cout (c)
    );

    // The output register is the only buffer, so a beat can enter whenever it is empty or draining.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign at_limit = (cnt == IDX_W'(MAX_BEATS - 1));
    assign last_eff = in_last || at_limit;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            out_carry <= 1'b0;
            out_ovf   <= 1'b0;
            out_err   <= 1'b0;
            carry_q   <= 1'b0;
            cnt       <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_sum   <= s;
            out_idx   <= cnt;
            out_last  <= last_eff;
            out_carry <= last_eff && c;
            out_ovf   <= last_eff && signed_ovf(in_a[WIDTH-1], in_b[WIDTH-1], s[WIDTH-1]);
            out_err   <= at_limit && !in_last;
            if (last_eff) begin
                carry_q <= 1'b0;
                cnt     <= '0;
            end else begin
                carry_q <= c;
                cnt     <= cnt + 1'b1;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
